// File: rtl/proc_pkg.sv
// Shared types for the parameterised processor core: opcodes, FSM states and
// the instruction-field width helper.
package proc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_LD  = 3'b100,
      OP_ST  = 3'b101,
      OP_LI  = 3'b110,
      OP_NOP = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   // fld must hold a register index, a memory address and an immediate
   function automatic int fw_calc(input int ra, input int da, input int dw);
      int m;
      m = (ra > da) ? ra : da;
      return (m > dw) ? m : dw;
   endfunction

endpackage

// File: rtl/param_regfile.sv
// RF_DEPTH x DW register file: one write port, two read ports, one debug read
// port, asynchronous clear.
module param_regfile #(
   parameter int DW    = 4,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   // Non power-of-two depths leave unused index codes; those read as zero
   localparam logic [AW:0] LIM = DEPTH[AW:0];

   logic [DEPTH-1:0][DW-1:0] mem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mem <= '0;
      else if (we && ({1'b0, waddr} < LIM))
         mem[waddr] <= wdata;
   end

   assign rdata_a  = ({1'b0, raddr_a}  < LIM) ? mem[raddr_a]  : '0;
   assign rdata_b  = ({1'b0, raddr_b}  < LIM) ? mem[raddr_b]  : '0;
   assign dbg_data = ({1'b0, dbg_addr} < LIM) ? mem[dbg_addr] : '0;

endmodule

// File: rtl/param_proc_core.sv
// Three-state (IDLE/EXEC/WB) processor core with register file and data memory.
// Optional signed-overflow flag output enabled by macro PROC_OVF_FLAG_EN.
module param_proc_core
   import proc_pkg::*;
#(
   parameter int DW       = 4,
   parameter int RF_DEPTH = 8,
   parameter int DM_DEPTH = 16,
   localparam int RA      = $clog2(RF_DEPTH),
   localparam int DA      = $clog2(DM_DEPTH),
   localparam int FW      = fw_calc(RA, DA, DW),
   localparam int IW      = 3 + 2*RA + FW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic          busy,
   output logic [DW-1:0] result,
   output logic          result_valid,
   input  logic [RA-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
`ifdef PROC_OVF_FLAG_EN
   ,
   output logic          ovf
`endif
);

   localparam logic [DA:0] DM_LIM = DM_DEPTH[DA:0];

   state_e                     state, state_nxt;
   logic [IW-1:0]              ir;
   op_e                        op;
   logic [RA-1:0]              rd, rs1, rs2;
   logic [FW-1:0]              fld;
   logic [DA-1:0]              maddr;
   logic                       maddr_ok;
   logic [DW-1:0]              rdata_a, rdata_b, alu_res, exec_res;
   logic [DM_DEPTH-1:0][DW-1:0] dm;
   logic                       rf_we, dm_we;

   assign op       = op_e'(ir[IW-1 -: 3]);
   assign rd       = ir[IW-4 -: RA];
   assign rs1      = ir[IW-4-RA -: RA];
   assign fld      = ir[FW-1:0];
   assign rs2      = fld[RA-1:0];
   assign maddr    = fld[DA-1:0];
   assign maddr_ok = {1'b0, maddr} < DM_LIM;

   param_regfile #(.DW(DW), .DEPTH(RF_DEPTH), .AW(RA)) u_rf (
      .clk      (clk),
      .reset    (reset),
      .we       (rf_we),
      .waddr    (rd),
      .wdata    (exec_res),
      .raddr_a  (rs1),
      .rdata_a  (rdata_a),
      .raddr_b  (rs2),
      .rdata_b  (rdata_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            // held low while reset is asserted even though the state reads IDLE
            instr_ready = reset;
            if (instr_valid) state_nxt = EXEC;
         end
         EXEC: begin
            busy      = 1'b1;
            state_nxt = WB;
         end
         WB: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = rdata_a + rdata_b;
         OP_SUB:  alu_res = rdata_a - rdata_b;
         OP_AND:  alu_res = rdata_a & rdata_b;
         OP_OR:   alu_res = rdata_a | rdata_b;
         OP_LD:   alu_res = maddr_ok ? dm[maddr] : '0;
         OP_ST:   alu_res = rdata_a;
         OP_LI:   alu_res = fld[DW-1:0];
         default: alu_res = '0;
      endcase
   end

   assign rf_we = (state == WB) && (op != OP_ST) && (op != OP_NOP);
   assign dm_we = (state == WB) && (op == OP_ST) && maddr_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ir           <= '0;
         exec_res     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         dm           <= '0;
      end else begin
         state        <= state_nxt;
         result_valid <= 1'b0;
         if (state == IDLE && instr_valid) ir <= instr;
         if (state == EXEC) exec_res <= alu_res;
         if (dm_we) dm[maddr] <= exec_res;
         if (rf_we || dm_we) begin
            result       <= exec_res;
            result_valid <= 1'b1;
         end
      end
   end

`ifdef PROC_OVF_FLAG_EN
   // Operands are still stable in WB: the RF write lands on the closing edge
   logic a_s, b_s, r_s;
   assign a_s = rdata_a[DW-1];
   assign b_s = rdata_b[DW-1];
   assign r_s = exec_res[DW-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ovf <= 1'b0;
      else if (state == WB && op == OP_ADD)
         ovf <= (a_s == b_s) && (r_s != a_s);
      else if (state == WB && op == OP_SUB)
         ovf <= (a_s != b_s) && (r_s != a_s);
   end
`endif

endmodule

// File: tb/tb_param_proc_core.sv
// Self-checking bench: two cores (DM_DEPTH 16 and 12) share one stimulus
// stream and are compared against an instruction-level reference model.
module tb_param_proc_core;

   localparam int DW = 4;
   localparam int RA = 3;
   localparam int IW = 13;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [IW-1:0] instr = '0;
   logic          instr_valid = 1'b0;
   logic [RA-1:0] dbg_addr = '0;
   logic [1:0]    instr_ready, busy, result_valid;
   logic [DW-1:0] result [2];
   logic [DW-1:0] dbg_data [2];
`ifdef PROC_OVF_FLAG_EN
   logic [1:0]    ovf;
`endif

   int checks = 0;
   int failures = 0;

   // reference model state, one copy per core
   int rf [2][8];
   int dm [2][16];
   int depth [2] = '{16, 12};
   int last_res [2];
   int ovf_m [2];
   int exp_we [2];

   always #5 clk = ~clk;

   param_proc_core #(.DW(4), .RF_DEPTH(8), .DM_DEPTH(16)) dut0 (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready[0]), .busy(busy[0]), .result(result[0]),
      .result_valid(result_valid[0]), .dbg_addr(dbg_addr), .dbg_data(dbg_data[0])
`ifdef PROC_OVF_FLAG_EN
      , .ovf(ovf[0])
`endif
   );

   param_proc_core #(.DW(4), .RF_DEPTH(8), .DM_DEPTH(12)) dut1 (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready[1]), .busy(busy[1]), .result(result[1]),
      .result_valid(result_valid[1]), .dbg_addr(dbg_addr), .dbg_data(dbg_data[1])
`ifdef PROC_OVF_FLAG_EN
      , .ovf(ovf[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int fld);
      return {op[2:0], rd[2:0], rs1[2:0], fld[3:0]};
   endfunction

   function automatic int sx(input int v);
      return (v >= 8) ? v - 16 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 8; r++) rf[i][r] = 0;
         for (int a = 0; a < 16; a++) dm[i][a] = 0;
         last_res[i] = 0;
         ovf_m[i] = 0;
      end
   endtask

   // architectural effect of one instruction on each core
   task automatic model(input logic [IW-1:0] ins);
      int op, rd, rs1, fld, a, b, s, r;
      op  = 32'(ins[12:10]);
      rd  = 32'(ins[9:7]);
      rs1 = 32'(ins[6:4]);
      fld = 32'(ins[3:0]);
      for (int i = 0; i < 2; i++) begin
         a = rf[i][rs1];
         b = rf[i][fld % 8];
         r = 0;
         exp_we[i] = 1;
         case (op)
            0: begin r = (a + b) % 16; s = sx(a) + sx(b); ovf_m[i] = int'(s > 7 || s < -8); end
            1: begin r = (a - b + 16) % 16; s = sx(a) - sx(b); ovf_m[i] = int'(s > 7 || s < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = (fld < depth[i]) ? dm[i][fld] : 0;
            5: begin r = a; if (fld < depth[i]) dm[i][fld] = a; else exp_we[i] = 0; end
            6: r = fld % 16;
            default: exp_we[i] = 0;
         endcase
         if (exp_we[i] != 0) last_res[i] = r;
         if (exp_we[i] != 0 && op != 5) rf[i][rd] = r;
      end
   endtask

   // issue one instruction and follow it through EXEC and WB
   task automatic run(input string tag, input logic [IW-1:0] ins);
      int rd;
      rd = 32'(ins[9:7]);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/%0d ready_idle", tag, i), instr_ready[i], 1);
         check($sformatf("%s/%0d rv_idle", tag, i), result_valid[i], 0);
      end
      instr = ins;
      instr_valid = 1'b1;
      dbg_addr = ins[9:7];
      model(ins);
      @(negedge clk);
      instr_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/%0d busy_exec", tag, i), busy[i], 1);
         check($sformatf("%s/%0d ready_exec", tag, i), instr_ready[i], 0);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/%0d busy_wb", tag, i), busy[i], 1);
         check($sformatf("%s/%0d rv_wb", tag, i), result_valid[i], 0);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/%0d rv", tag, i), result_valid[i], exp_we[i]);
         check($sformatf("%s/%0d result", tag, i), result[i], last_res[i]);
         check($sformatf("%s/%0d dbg", tag, i), dbg_data[i], rf[i][rd]);
         check($sformatf("%s/%0d ready_after", tag, i), instr_ready[i], 1);
         check($sformatf("%s/%0d busy_after", tag, i), busy[i], 0);
`ifdef PROC_OVF_FLAG_EN
         check($sformatf("%s/%0d ovf", tag, i), ovf[i], ovf_m[i]);
`endif
      end
   endtask

   task automatic chk_rf(input string tag);
      for (int r = 0; r < 8; r++) begin
         dbg_addr = 3'(r);
         #1;
         for (int i = 0; i < 2; i++)
            check($sformatf("%s/%0d R%0d", tag, i, r), dbg_data[i], rf[i][r]);
      end
   endtask

   logic [IW-1:0] bb [3];
   int acc [3];
   int nacc;

   initial begin
      model_reset();
      // reset state
      #2;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst/%0d ready", i), instr_ready[i], 0);
         check($sformatf("rst/%0d busy", i), busy[i], 0);
         check($sformatf("rst/%0d rv", i), result_valid[i], 0);
         check($sformatf("rst/%0d result", i), result[i], 0);
      end
      chk_rf("rst");
      @(negedge clk);
      reset = 1'b1;

      // basic ALU
      run("li_r1", enc(6, 1, 0, 5));
      run("li_r2", enc(6, 2, 0, 3));
      run("add_r3", enc(0, 3, 1, 2));
      check("add_r3 const", dbg_data[0], 8);
      run("sub_r4", enc(1, 4, 2, 1));
      check("sub_r4 const", dbg_data[0], 14);
      run("li_r5", enc(6, 5, 0, 7));
      run("li_r6", enc(6, 6, 0, 1));
      run("add_r7", enc(0, 7, 5, 6));
      check("add_r7 const", dbg_data[0], 8);
`ifdef PROC_OVF_FLAG_EN
      check("add_r7 ovf const", ovf[0], 1);
`endif
      run("and", enc(2, 0, 3, 4));
      run("or", enc(3, 0, 2, 1));

      // memory
      run("li9", enc(6, 1, 0, 9));
      run("st12", enc(5, 0, 1, 12));
      check("st12 result const", result[0], 9);
      run("ld12", enc(4, 2, 0, 12));
      check("ld12 r2 const", dbg_data[0], 9);
      run("li6", enc(6, 1, 0, 6));
      run("st13", enc(5, 0, 1, 13));
      run("ld13", enc(4, 3, 0, 13));
      check("ld13 oob const", dbg_data[1], 0);
      for (int a = 0; a < 12; a++)
         run($sformatf("scan%0d", a), enc(4, 4, 0, a));
      run("nop", enc(7, 5, 5, 3));

      // back-to-back with instr_valid held
      bb[0] = enc(6, 1, 0, 11);
      bb[1] = enc(6, 2, 0, 4);
      bb[2] = enc(6, 3, 0, 13);
      nacc = 0;
      @(negedge clk);
      instr = bb[0];
      instr_valid = 1'b1;
      for (int cyc = 0; cyc < 20 && nacc < 3; cyc++) begin
         if (instr_ready[0]) begin
            acc[nacc] = cyc;
            model(bb[nacc]);
            nacc++;
         end
         @(negedge clk);
         if (nacc < 3) instr = bb[nacc];
         else instr_valid = 1'b0;
      end
      instr_valid = 1'b0;
      check("b2b accepts", nacc, 3);
      if (nacc == 3) begin
         check("b2b first", acc[0], 0);
         check("b2b gap1", acc[1] - acc[0], 3);
         check("b2b gap2", acc[2] - acc[1], 3);
      end
      repeat (3) @(negedge clk);
      chk_rf("b2b");

      // randomized instruction stream
      for (int n = 0; n < 60; n++)
         run($sformatf("rnd%0d", n),
             enc(int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(7)), int'($urandom_range(15))));
      chk_rf("rnd");

      // reset during EXEC aborts the write
      run("rli1", enc(6, 1, 0, 5));
      run("rli2", enc(6, 2, 0, 3));
      @(negedge clk);
      instr = enc(0, 3, 1, 2);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      check("abort busy_exec", busy[0], 1);
      reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort/%0d ready_low", i), instr_ready[i], 0);
         check($sformatf("abort/%0d busy_low", i), busy[i], 0);
         check($sformatf("abort/%0d rv_low", i), result_valid[i], 0);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("abort/%0d ready_rel", i), instr_ready[i], 1);
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            check($sformatf("abort/%0d rv_quiet", i), result_valid[i], 0);
      end
      dbg_addr = 3'd3;
      #1;
      check("abort r3 const", dbg_data[0], 0);
      chk_rf("abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/param_proc_core.md
PARAM_PROC_CORE -- requirements
Module: param_proc_core

Interface
REQ-001 Parameter DW, default 4: data word width in bits; allowed range 2..16.
REQ-002 Parameter RF_DEPTH, default 8: register-file entries, RA = clog2(RF_DEPTH).
REQ-003 Parameter DM_DEPTH, default 16: data-memory words, DA = clog2(DM_DEPTH).
REQ-004 Derived constants: FW = max(RA, DA, DW); IW = 3 + 2*RA + FW (13 at defaults).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 instr  in  IW  instruction {op[2:0], rd[RA], rs1[RA], fld[FW]}.
REQ-009 instr_valid  in  1  instr holds a valid instruction.
REQ-010 instr_ready  out  1  core accepts an instruction this cycle.
REQ-011 busy  out  1  an instruction is in flight.
REQ-012 result  out  DW  last value written to RF or DM.
REQ-013 result_valid  out  1  single-cycle pulse on every RF/DM write.
REQ-014 dbg_addr  in  RA  debug read address; dbg_data  out  DW  combinational RF[dbg_addr].

Function
REQ-015 Opcodes: 000 ADD rd=rs1+rs2; 001 SUB rd=rs1-rs2; 010 AND; 011 OR; 100 LD rd=DM[fld]; 101 ST DM[fld]=R[rs1]; 110 LI rd=fld[DW-1:0]; 111 NOP; rs2 = fld[RA-1:0].
REQ-016 FSM states IDLE, EXEC, WB; IDLE->EXEC on instr_valid&&instr_ready (instr latched); EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-017 instr_ready = 1 only in IDLE; busy = 1 in EXEC and WB.
REQ-018 Instruction accepted at edge N: EXEC computes ALU/memory read, write commits at edge N+2, result_valid high in the cycle after that edge, instr_ready high again in the same cycle.
REQ-019 Arithmetic is modulo 2^DW; no carry output.
REQ-020 Memory address = fld[DA-1:0]; address >= DM_DEPTH: ST writes nothing, LD returns 0.
REQ-021 NOP traverses EXEC and WB with no write and no result_valid pulse.
REQ-022 instr_valid while busy is ignored; the held instruction is accepted in the next IDLE cycle.
REQ-023 dbg_data reflects a WB write from the cycle after the committing edge.

Reset
REQ-024 reset low clears all RF and DM entries to 0, FSM to IDLE, result=0, result_valid=0, busy=0, instr_ready=0 while reset is asserted.
REQ-025 Reset during EXEC or WB aborts the instruction with no write; instr_ready=1 in the first cycle after reset release.

Configuration
REQ-026 Macro PROC_OVF_FLAG_EN defined: output ovf (1 bit, reset 0) updates at WB of ADD/SUB with two's-complement signed overflow and holds otherwise.
REQ-027 PROC_OVF_FLAG_EN undefined: no ovf port; all other behaviour identical.

Structure
REQ-028 Package proc_pkg holds the opcode enum, FSM state enum and the width-derivation helper for FW.
REQ-029 Sub-module param_regfile (RF_DEPTH x DW; one write port; two read ports plus debug read port; asynchronous clear) is instantiated once.

Verification
REQ-030 LI R1,5; LI R2,3; ADD R3,R1,R2 -> dbg R3=8, result=8, one result_valid pulse per instruction.
REQ-031 SUB R4,R2,R1 (3-5) -> R4=0xE; with PROC_OVF_FLAG_EN, LI R5,7; LI R6,1; ADD R7,R5,R6 -> R7=8, ovf=1.
REQ-032 LI R1,9; ST fld=12,R1; LD R2,fld=12 -> R2=9, result=9 on both ST and LD.
REQ-033 instr_valid held high across 3 back-to-back instructions -> each accepted exactly 3 cycles apart, instr_ready low for 2 cycles after each accept.
REQ-034 Accept ADD R3,R1,R2 with R1=5, R2=3, then pulse reset during EXEC -> R3=0, no result_valid, instr_ready=1 in the first cycle after release.
REQ-035 DM_DEPTH=12: ST fld=13 followed by LD fld=13 -> LD returns 0 and no DM location changes.
